// File: rtl/cos_useq_ctrl.sv
// cos_useq_ctrl: micro-program sequencer for the cosine-similarity datapath.
// It owns the uprogram PC and the vector-element index. For each element it
// runs one full pass of PROG_LEN uops. At the end of each pass it jumps back
// to PC 0. After the last pass it spends one cycle in DONE.
module cos_useq_ctrl #(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 10,
  parameter int IDX_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [IDX_W-1:0] vec_len_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             uop_valid_o,
  output logic             clear_acc_o,
  output logic             last_elem_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Address of the final uop in a pass. When PROG_LEN == 2**PC_W this is
  // the all-ones address, so the PC never has to wrap.
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] len_m1;
  logic             start_acc;
  logic             uop_acc;
  logic             pc_at_last;
  logic             idx_at_last;

  // Abort wins over start in IDLE, so a start only counts when abort is low.
  assign start_acc   = (state_q == ST_IDLE) & start_i & ~abort_i;
  assign uop_acc     = (state_q == ST_RUN) & ~stall_i;
  assign len_m1      = len_q - IDX_W'(1);
  assign pc_at_last  = (pc_q == PC_LAST);
  assign idx_at_last = (idx_q == len_m1);

  // Sequencer FSM: state, PC, element index and latched vector length.
  // NOTE: all state here uses non-blocking assignments. Every flop then
  // samples pre-edge values, so the ordering of statements inside the block
  // does not change the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            len_q   <= vec_len_i;
            pc_q    <= '0;
            idx_q   <= '0;
            state_q <= (vec_len_i != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            idx_q   <= '0;
          end else if (uop_acc) begin
            if (!pc_at_last) begin
              pc_q <= pc_q + PC_W'(1);
            end else if (!idx_at_last) begin
              pc_q  <= '0;
              idx_q <= idx_q + IDX_W'(1);
            end else begin
              // The last uop of the last element was accepted. PC and index
              // keep their final values through the DONE cycle.
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          pc_q    <= '0;
          idx_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          pc_q    <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded directly from the registered state. clear_acc_o is
  // the exception: it has to fire in the same cycle the start is accepted.
  assign pc_o        = pc_q;
  assign idx_o       = idx_q;
  assign uop_valid_o = (state_q == ST_RUN);
  assign clear_acc_o = start_acc;
  assign last_elem_o = (state_q == ST_RUN) & idx_at_last;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cos_useq_ctrl.sv
// Self-checking bench for cos_useq_ctrl.
// When a job starts, the stimulus pushes the complete expected output stream
// into a queue: every (pc, idx, last) uop, followed by one done marker. A
// monitor on the falling clock edge compares each presented output against
// the head of the queue.
`timescale 1ns/1ps
module tb_cos_useq_ctrl;
  localparam int PC_W     = 2;
  localparam int PROG_LEN = 4;   // equal to 2**PC_W, so the jump happens at the all-ones PC
  localparam int IDX_W    = 8;
  localparam int BUDGET   = 5000;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [IDX_W-1:0] vec_len_i = '0;
  logic             stall_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [PC_W-1:0]  pc_o;
  logic [IDX_W-1:0] idx_o;
  logic             uop_valid_o, clear_acc_o, last_elem_o, busy_o, done_o;

  typedef struct {
    bit is_done;
    int pc;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  cos_useq_ctrl #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .IDX_W(IDX_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .vec_len_i   (vec_len_i),
    .stall_i     (stall_i),
    .abort_i     (abort_i),
    .pc_o        (pc_o),
    .idx_o       (idx_o),
    .uop_valid_o (uop_valid_o),
    .clear_acc_o (clear_acc_o),
    .last_elem_o (last_elem_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one job. The expected stream is every element in
  // order, with a full pass of PROG_LEN uops per element, then a done marker.
  // During DONE the PC and index keep their last values.
  task automatic push_job(input int len);
    exp_t e;
    for (int el = 0; el < len; el++) begin
      for (int p = 0; p < PROG_LEN; p++) begin
        e.is_done = 1'b0; e.pc = p; e.idx = el; e.last = (el == len - 1);
        sb.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.pc      = (len > 0) ? PROG_LEN - 1 : 0;
    e.idx     = (len > 0) ? len - 1 : 0;
    e.last    = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: compare every presented uop or done cycle against the queue head.
  // A stalled uop is compared but not popped, so the held values are checked too.
  always @(negedge clk_i) begin
    if (rst_ni && (uop_valid_o || done_o)) begin
      check("valid_done_excl", 32'(uop_valid_o & done_o), 32'd0);
      check("busy_when_active", 32'(busy_o), 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: valid=%0b done=%0b pc=%0d idx=%0d, expected no output (t=%0t)",
                 uop_valid_o, done_o, pc_o, idx_o, $time);
      end else begin
        mon_e = sb[0];
        check("out_kind_done", 32'(done_o), 32'(mon_e.is_done));
        check("pc", 32'(pc_o), 32'(mon_e.pc));
        check("idx", 32'(idx_o), 32'(mon_e.idx));
        check("last_elem", 32'(last_elem_o), 32'(mon_e.last));
        if (done_o || !stall_i) void'(sb.pop_front());
      end
    end
  end

  // Run one job. Call this at posedge+1 with the DUT idle.
  //   sp/si : stall for 3 cycles the first time the uop at (pc=sp, idx=si) is seen
  //   ap/ai : abort at the uop (pc=ap, idx=ai)
  //   noise : when >= 0, assert start_i randomly with vec_len_i = noise while running
  task automatic run_job(input int len, input int stall_pct, input int abort_pml, input int noise,
                         input int sp, input int si, input int ap, input int ai,
                         output int cyc, output bit aborted);
    int n_valid, n_stall, stall_left;
    start_i = 1'b1; vec_len_i = IDX_W'(len); stall_i = 1'b0; abort_i = 1'b0;
    #1 check("clear_acc_on_start", 32'(clear_acc_o), 32'd1);
    push_job(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    cyc = 0; n_valid = 0; n_stall = 0; stall_left = 3; aborted = 1'b0;
    while (busy_o && cyc < BUDGET) begin
      cyc++;
      stall_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
      if (uop_valid_o) begin
        n_valid++;
        if (sp >= 0 && int'(pc_o) == sp && int'(idx_o) == si && stall_left > 0) begin
          stall_i = 1'b1; stall_left--;
        end else if (int'($urandom_range(99)) < stall_pct) begin
          stall_i = 1'b1;
        end
        if (stall_i) n_stall++;
        if ((ap >= 0 && int'(pc_o) == ap && int'(idx_o) == ai) ||
            int'($urandom_range(999)) < abort_pml) abort_i = 1'b1;
        if (noise >= 0) begin
          start_i = 1'($urandom_range(1)); vec_len_i = IDX_W'(noise);
        end
      end
      @(posedge clk_i); #1;
      if (abort_i) begin
        aborted = 1'b1;
        sb.delete();
      end
    end
    start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
    check("job_in_budget", 32'(cyc < BUDGET), 32'd1);
    if (!aborted) begin
      check("job_cycles", 32'(cyc), 32'(len * PROG_LEN + n_stall + 1));
      check("job_valid_cycles", 32'(n_valid), 32'(len * PROG_LEN + n_stall));
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int cyc, len, wait_n;
    bit ab;
    #12;
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    check("rst_outs", 32'({uop_valid_o, clear_acc_o, last_elem_o, busy_o, done_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // len=3, no stalls: 12 uops, then done.
    run_job(3, 0, 0, -1, -1, 0, -1, 0, cyc, ab);
    check("len3_cycles", 32'(cyc), 32'd13);
    // Stall for 3 cycles at pc=2, idx=1.
    run_job(3, 0, 0, -1, 2, 1, -1, 0, cyc, ab);
    check("stall_cycles", 32'(cyc), 32'd16);
    // Zero length: only the DONE cycle.
    run_job(0, 0, 0, -1, -1, 0, -1, 0, cyc, ab);
    check("len0_cycles", 32'(cyc), 32'd1);
    // start with vec_len_i=7 while running must be ignored; a later start latches 7.
    run_job(3, 0, 0, 7, -1, 0, -1, 0, cyc, ab);
    check("ignored_start_cycles", 32'(cyc), 32'd13);
    run_job(7, 0, 0, -1, -1, 0, -1, 0, cyc, ab);
    check("len7_cycles", 32'(cyc), 32'd29);
    // Abort at pc=1, idx=2 with len=5.
    run_job(5, 0, 0, -1, -1, 0, 1, 2, cyc, ab);
    check("abort_seen", 32'(ab), 32'd1);
    check("abort_cycles", 32'(cyc), 32'd10);
    check("abort_state", 32'({pc_o, idx_o, busy_o, done_o}), 32'd0);
    // In IDLE, abort wins over start.
    start_i = 1'b1; abort_i = 1'b1; vec_len_i = 8'd5;
    #1 check("abort_blocks_clear", 32'(clear_acc_o), 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_blocks_start", 32'(busy_o), 32'd0);
    run_job(2, 0, 0, -1, -1, 0, -1, 0, cyc, ab);
    check("after_abort_cycles", 32'(cyc), 32'd9);
    // Maximum length: the last element has idx 254.
    run_job(255, 0, 0, -1, -1, 0, -1, 0, cyc, ab);

    // Asynchronous reset in the middle of a run, at pc=3, idx=1.
    start_i = 1'b1; vec_len_i = 8'd3;
    push_job(3);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_n = 0;
    while (!(uop_valid_o && pc_o == 2'd3 && idx_o == 8'd1) && wait_n < 50) begin
      @(posedge clk_i); #1; wait_n++;
    end
    check("reach_pc3_idx1", 32'(wait_n < 50), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pc_idx", 32'({pc_o, idx_o}), 32'd0);
    check("async_rst_outs", 32'({uop_valid_o, last_elem_o, busy_o, done_o}), 32'd0);
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 check("idle_after_rst", 32'({busy_o, uop_valid_o, pc_o, idx_o}), 32'd0);

    // Randomised jobs with stalls, stray starts and occasional aborts.
    for (int j = 0; j < 30; j++) begin
      len = ($urandom_range(9) < 7) ? int'($urandom_range(6)) : int'($urandom_range(40));
      run_job(len, 20, 4, int'($urandom_range(255)), -1, 0, -1, 0, cyc, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
